// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button conditioner: FSM encodings and default timing.
// The default constants are also picked up by the traffic-light top.
package btn_conditioner_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      PRESSED      = 3'd2,
      LONG         = 3'd3,
      RELEASE_WAIT = 3'd4
   } btn_state_e;

   localparam int BTN_DEBOUNCE_DEF = 20;
   localparam int BTN_LONG_DEF     = 500;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, synchronous active-low reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the raw push-button and emits registered press/release/long-press
// pulses plus clean level and held indications.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
   parameter int LONG_CYCLES     = BTN_LONG_DEF
) (
   input  logic clk,
   input  logic btn_res,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_long,
   output logic btn_held
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] D_MAX  = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

   logic          s;
   btn_state_e    state, state_d;
   logic [DW-1:0] deb_cnt, deb_d, deb_inc;
   logic [HW-1:0] hold_cnt, hold_d, hold_inc;
   logic          was_long, was_long_d;
   logic          level_d, press_d, release_d, long_d, held_d;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk   (clk),
      .rst_n (btn_res),
      .d     (btn_raw),
      .q     (s)
   );

   // Saturating increments; the counters never wrap.
   assign deb_inc  = (deb_cnt  == D_MAX) ? deb_cnt  : deb_cnt  + DW'(1);
   assign hold_inc = (hold_cnt == H_MAX) ? hold_cnt : hold_cnt + HW'(1);

   always_ff @(posedge clk) begin
      if (!btn_res) begin
         state       <= IDLE;
         deb_cnt     <= '0;
         hold_cnt    <= '0;
         was_long    <= 1'b0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
         btn_long    <= 1'b0;
         btn_held    <= 1'b0;
      end else begin
         state       <= state_d;
         deb_cnt     <= deb_d;
         hold_cnt    <= hold_d;
         was_long    <= was_long_d;
         btn_level   <= level_d;
         btn_press   <= press_d;
         btn_release <= release_d;
         btn_long    <= long_d;
         btn_held    <= held_d;
      end
   end

   always_comb begin
      state_d    = state;
      deb_d      = deb_cnt;
      hold_d     = hold_cnt;
      was_long_d = was_long;
      level_d    = btn_level;
      held_d     = btn_held;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      unique case (state)
         IDLE: begin
            if (s) begin
               state_d = PRESS_WAIT;
               deb_d   = DW'(1);
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_d = IDLE;
               deb_d   = '0;
            end else if (deb_cnt == D_LAST) begin
               state_d = PRESSED;
               deb_d   = '0;
               hold_d  = '0;
               press_d = 1'b1;
               level_d = 1'b1;
            end else begin
               deb_d = deb_inc;
            end
         end
         PRESSED: begin
            // A falling sample freezes the hold count until the release resolves.
            if (!s) begin
               state_d    = RELEASE_WAIT;
               was_long_d = 1'b0;
               deb_d      = DW'(1);
            end else if (hold_cnt == H_LAST) begin
               state_d = LONG;
               hold_d  = hold_inc;
               long_d  = 1'b1;
               held_d  = 1'b1;
            end else begin
               hold_d = hold_inc;
            end
         end
         LONG: begin
            if (!s) begin
               state_d    = RELEASE_WAIT;
               was_long_d = 1'b1;
               deb_d      = DW'(1);
            end
         end
         RELEASE_WAIT: begin
            if (s) begin
               state_d = was_long ? LONG : PRESSED;
               deb_d   = '0;
            end else if (deb_cnt == D_LAST) begin
               state_d   = IDLE;
               deb_d     = '0;
               release_d = 1'b1;
               level_d   = 1'b0;
               held_d    = 1'b0;
            end else begin
               deb_d = deb_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: stimulus queues expected events with their cycle, a
// negedge monitor pops and compares whenever a pulse appears.
module tb_btn_conditioner;

   localparam int D = 4;
   localparam int L = 16;
   localparam int EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2;

   logic clk = 1'b0;
   logic btn_res = 1'b0;
   logic btn_raw = 1'b0;
   logic btn_level, btn_press, btn_release, btn_long, btn_held;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int kind;
      int at;
   } ev_t;
   ev_t q[$];

   btn_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
      .clk         (clk),
      .btn_res     (btn_res),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long),
      .btn_held    (btn_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // A pulse visible after edge n is reported as "at" edge n+1.
   task automatic chk_ev(input int k);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         failures++;
         $display("FAIL event: unexpected kind=%0d at cycle %0d, none expected", k, cyc + 1);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.at != cyc + 1) begin
            failures++;
            $display("FAIL event: got kind=%0d at %0d, expected kind=%0d at %0d",
                     k, cyc + 1, e.kind, e.at);
         end
      end
   endtask

   always @(negedge clk) begin
      if (btn_press)   chk_ev(EV_PRESS);
      if (btn_long)    chk_ev(EV_LONG);
      if (btn_release) chk_ev(EV_RELEASE);
   end

   task automatic push(input int k, input int at);
      ev_t e;
      e.kind = k;
      e.at   = at;
      q.push_back(e);
   endtask

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b, expected %b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string name);
      logic [4:0] v;
      v = {btn_level, btn_press, btn_release, btn_long, btn_held};
      checks++;
      if (v !== 5'b0) begin
         failures++;
         $display("FAIL %s: outputs %b, expected 00000 at cycle %0d", name, v, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL %s: %0d expected events never seen, expected 0 pending", name, q.size());
         q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1;
      logic [6:0] bounce;

      // 1: reset held with raw high
      btn_res = 1'b0;
      btn_raw = 1'b1;
      @(negedge clk); chk_zero("reset_a");
      @(negedge clk); chk_zero("reset_b");
      btn_res = 1'b1;
      t0 = cyc + 1;
      push(EV_PRESS, t0 + 6);
      idle(8);
      check("t1_level_hi", btn_level, 1'b1);
      btn_raw = 1'b0;
      t1 = cyc + 1;
      push(EV_RELEASE, t1 + 6);
      drain("t1_drain", 20);
      check("t1_level_lo", btn_level, 1'b0);
      idle(3);

      // 2: clean 10-cycle press, no long
      btn_raw = 1'b1;
      t0 = cyc + 1;
      push(EV_PRESS, t0 + 6);
      idle(10);
      check("t2_level_hi", btn_level, 1'b1);
      check("t2_held_lo", btn_held, 1'b0);
      btn_raw = 1'b0;
      t1 = cyc + 1;
      push(EV_RELEASE, t1 + 6);
      drain("t2_drain", 30);
      check("t2_level_lo", btn_level, 1'b0);
      idle(3);

      // 3: bounce 3 high, 1 low, 2 high, 1 low, then steady
      bounce = 7'b0110111;
      for (int i = 0; i < 7; i++) begin
         btn_raw = bounce[i];
         @(negedge clk);
      end
      btn_raw = 1'b1;
      t0 = cyc + 1;
      push(EV_PRESS, t0 + 6);
      idle(8);
      btn_raw = 1'b0;
      t1 = cyc + 1;
      push(EV_RELEASE, t1 + 6);
      drain("t3_drain", 30);
      idle(3);

      // 4: 30-cycle hold reaches long press
      btn_raw = 1'b1;
      t0 = cyc + 1;
      push(EV_PRESS, t0 + 6);
      push(EV_LONG, t0 + 22);
      idle(20);
      check("t4_held_before_long", btn_held, 1'b0);
      idle(10);
      check("t4_held_hi", btn_held, 1'b1);
      btn_raw = 1'b0;
      t1 = cyc + 1;
      push(EV_RELEASE, t1 + 6);
      idle(5);
      check("t4_held_still_hi", btn_held, 1'b1);
      drain("t4_drain", 30);
      check("t4_held_lo", btn_held, 1'b0);
      idle(3);

      // 5: 2-cycle glitch while in LONG
      btn_raw = 1'b1;
      t0 = cyc + 1;
      push(EV_PRESS, t0 + 6);
      push(EV_LONG, t0 + 22);
      idle(25);
      btn_raw = 1'b0;
      idle(2);
      btn_raw = 1'b1;
      idle(8);
      check("t5_held_after_glitch", btn_held, 1'b1);
      check("t5_level_after_glitch", btn_level, 1'b1);
      btn_raw = 1'b0;
      t1 = cyc + 1;
      push(EV_RELEASE, t1 + 6);
      drain("t5_drain", 30);
      idle(3);

      // 6: reset lands mid-debounce
      btn_raw = 1'b1;
      idle(4);
      btn_res = 1'b0;
      @(negedge clk); chk_zero("t6_reset_a");
      @(negedge clk); chk_zero("t6_reset_b");
      btn_res = 1'b1;
      t0 = cyc + 1;
      push(EV_PRESS, t0 + 6);
      idle(8);
      btn_raw = 1'b0;
      t1 = cyc + 1;
      push(EV_RELEASE, t1 + 6);
      drain("t6_drain", 30);
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
